// File: rtl/reg_pipe.sv
// Elastic multi-stage pipeline register with valid/ready handshake,
// bubble collapsing, synchronous flush and occupancy count.
module reg_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(STAGES+1)-1:0]  o_count
);

  localparam int CW = $clog2(STAGES+1);

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     v_nxt;
  logic [STAGES-1:0]     load;
  logic [STAGES-1:0]     src_v;
  logic [DATA_WIDTH-1:0] d     [STAGES];
  logic [DATA_WIDTH-1:0] src_d [STAGES];
  logic [CW-1:0]         cnt_nxt;
  logic                  stall;

  // A stage stalls only if it and every stage below it are full
  // while the output is blocked.
  always_comb begin
    stall = ~i_ready;
    load  = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      stall   = stall & v[k];
      load[k] = ~stall;
    end
  end

  assign o_ready = load[0] & ~i_flush;

  always_comb begin
    src_v    = '0;
    src_v[0] = i_valid & o_ready;
    for (int k = 0; k < STAGES; k++) begin
      src_d[k] = i_data;
    end
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  always_comb begin
    v_nxt = v;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) v_nxt[k] = src_v[k];
    end
    if (i_flush) v_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      cnt_nxt = cnt_nxt + CW'(v_nxt[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v       <= '0;
      o_count <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= RST_VALUE;
      end
    end else begin
      v       <= v_nxt;
      o_count <= cnt_nxt;
      // Bubbles and flushes leave the data registers untouched.
      for (int k = 0; k < STAGES; k++) begin
        if (load[k] & src_v[k] & ~i_flush) d[k] <= src_d[k];
      end
    end
  end

  assign o_valid = v[STAGES-1];
  assign o_data  = d[STAGES-1];

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: 3- and 4-stage instances driven in parallel and
// compared each cycle against a beat-position queue model.
module tb_reg_pipe;

  localparam logic [31:0] RSTV = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  logic        rdy3, vld3, rdy4, vld4;
  logic [31:0] dat3, dat4;
  logic [1:0]  cnt3;
  logic [2:0]  cnt4;

  int n_chk;
  int n_pass;
  bit known;

  int          mpos [2][4];
  logic [31:0] mdat [2][4];
  int          mn   [2];
  logic [31:0] mlast[2];
  logic        mrdy [2];

  reg_pipe #(.DATA_WIDTH(32), .STAGES(3), .RST_VALUE(RSTV)) u3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(valid), .o_ready(rdy3), .i_data(data),
    .o_valid(vld3), .i_ready(ready), .o_data(dat3),
    .o_count(cnt3)
  );

  reg_pipe #(.DATA_WIDTH(32), .STAGES(4), .RST_VALUE(RSTV)) u4 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(valid), .o_ready(rdy4), .i_data(data),
    .o_valid(vld4), .i_ready(ready), .o_data(dat4),
    .o_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int stg(input int m);
    return (m == 0) ? 3 : 4;
  endfunction

  function automatic logic exp_valid(input int m);
    return (mn[m] > 0) && (mpos[m][0] == stg(m) - 1);
  endfunction

  function automatic logic [31:0] exp_data(input int m);
    return exp_valid(m) ? mdat[m][0] : mlast[m];
  endfunction

  task automatic model_step(input int m, input logic v, input logic [31:0] d,
                            input logic r, input logic f, input logic rs);
    int  s;
    int  lim;
    int  p;
    logic dlv;
    logic acc;
    s = stg(m);
    if (rs) begin
      mn[m]    = 0;
      mlast[m] = RSTV;
      return;
    end
    dlv = exp_valid(m) && r;
    acc = v && mrdy[m];
    if (dlv) begin
      for (int i = 0; i < 3; i++) begin
        mpos[m][i] = mpos[m][i+1];
        mdat[m][i] = mdat[m][i+1];
      end
      mn[m]--;
    end
    if (f) begin
      mn[m] = 0;
      return;
    end
    lim = s - 1;
    for (int i = 0; i < mn[m]; i++) begin
      p = mpos[m][i] + 1;
      if (p > lim) p = lim;
      if (p == s - 1 && mpos[m][i] != s - 1) mlast[m] = mdat[m][i];
      mpos[m][i] = p;
      lim = p - 1;
    end
    if (acc) begin
      mpos[m][mn[m]] = 0;
      mdat[m][mn[m]] = d;
      mn[m]++;
      if (s == 1) mlast[m] = d;
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                     input logic f, input logic rs);
    valid = v;
    data  = d;
    ready = r;
    flush = f;
    rst   = rs;
    #1;
    for (int m = 0; m < 2; m++) begin
      mrdy[m] = !f && !(mn[m] == stg(m) && !r);
    end
    if (known) begin
      chk("rdy3", rdy3, mrdy[0]);
      chk("vld3", vld3, exp_valid(0));
      chk("dat3", dat3, exp_data(0));
      chk("cnt3", cnt3, mn[0]);
      chk("rdy4", rdy4, mrdy[1]);
      chk("vld4", vld4, exp_valid(1));
      chk("dat4", dat4, exp_data(1));
      chk("cnt4", cnt4, mn[1]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, v, d, r, f, rs);
    if (rs) known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    known  = 1'b0;
    mn[0]  = 0;
    mn[1]  = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    valid  = 1'b0;
    ready  = 1'b0;
    data   = '0;
    @(negedge clk);

    // reset held two cycles with a beat offered
    cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rst_vld3", vld3, 32'd0);
    chk("rst_dat3", dat3, RSTV);
    chk("rst_cnt3", cnt3, 32'd0);
    chk("rst_rdy3", rdy3, 32'd1);
    chk("rst_dat4", dat4, RSTV);
    chk("rst_cnt4", cnt4, 32'd0);

    // back-to-back stream
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // backpressure fill then release
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_rdy3", rdy3, 32'd0);
    chk("bp_dat3", dat3, 32'hA);
    chk("bp_cnt3", cnt3, 32'd3);
    cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // bubble collapse
    cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bub_cnt4", cnt4, 32'd2);
    chk("bub_dat4", dat4, 32'h1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // flush with a beat offered
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fl_vld3", vld3, 32'd0);
    chk("fl_cnt3", cnt3, 32'd0);
    chk("fl_cnt4", cnt4, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // full push/pop, then reset together with flush
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h70 + 32'(i), 1'b1, 1'b0, 1'b0);
    #1;
    chk("pp_cnt3", cnt3, 32'd3);
    chk("pp_cnt4", cnt4, 32'd4);
    cyc(1'b1, 32'h99, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rf_vld3", vld3, 32'd0);
    chk("rf_dat3", dat3, RSTV);
    chk("rf_cnt3", cnt3, 32'd0);
    chk("rf_dat4", dat4, RSTV);
    chk("rf_vld4", vld4, 32'd0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 1);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised elastic pipeline register: a chain of `STAGES` data-holding stages with valid/ready handshake on both sides, per-stage bubble collapsing, synchronous flush and an occupancy count. It is the general-purpose successor to the single-stage reset register. It is inserted on long datapaths or between pipeline units wherever a fixed register delay must also honour backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width in bits (>= 1).
- `STAGES`, 2, number of register stages (>= 1).
- `RST_VALUE`, 0, value loaded into every data stage on reset.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  input  1  clock, all state updates on rising edge.
- `i_rst`  input  1  synchronous active-high reset.
- `i_flush`  input  1  synchronous flush; discards all held beats.
- `i_valid`  input  1  upstream beat present.
- `o_ready`  output  1  pipeline can accept a beat this cycle.
- `i_data`  input  DATA_WIDTH  upstream payload.
- `o_valid`  output  1  output stage holds a beat.
- `i_ready`  input  1  downstream accepts the beat this cycle.
- `o_data`  output  DATA_WIDTH  payload of output stage.
- `o_count`  output  $clog2(STAGES+1)  number of valid stages.

## Operation
- Stage 0 is at the input; stage `STAGES-1` drives `o_valid`/`o_data`. Each stage k holds `v[k]` and `d[k]`.
- Output take: `take[STAGES-1] = v[STAGES-1] & i_ready`. For k < STAGES-1: `take[k] = v[k] & load[k+1]`.
- Stage load: `load[k] = ~v[k] | take[k]`.
- On `load[k]`, stage k captures the previous stage: `v[k] <= v[k-1]`, `d[k] <= d[k-1]`. For k = 0 the source is `i_valid & o_ready` and `i_data`.
- `d[k]` is written only when the incoming valid is 1. Bubbles do not overwrite data.
- When `load[k]` is 0, the stage holds its value.
- `o_ready = load[0] & ~i_flush`. The ready path is combinational from `i_ready` through the chain. No skid buffer.
- Bubbles collapse: an empty stage fills from upstream even while downstream is stalled.
- A beat is transferred upstream when `i_valid & o_ready`, and downstream when `o_valid & i_ready`.
- Flush: all `v[k] <= 0` and `o_count <= 0`. Data registers retain their contents. The input beat in the flush cycle is not accepted, since `o_ready` is 0. Any output handshake occurring in the flush cycle still counts as delivered.
- Reset: all `v[k] <= 0`, all `d[k] <= RST_VALUE`, `o_count <= 0`. Reset overrides flush and all handshakes.
- `o_count` is registered and equals the popcount of `v` after each edge. It never exceeds `STAGES`.
- Order is strictly FIFO. No beat is dropped or duplicated except by flush or reset.

## Timing
- Reset values: `o_valid = 0`, `o_data = RST_VALUE`, `o_count = 0`. `o_ready = 1` unless `i_flush` is high.
- Latency: a beat accepted at edge t into an empty pipeline with `i_ready` held high gives `o_valid = 1` after edge t+STAGES-1. It is visible `STAGES` cycles after its `i_valid` cycle.
- Throughput: 1 beat/cycle sustained when `i_ready = 1`.
- Stall: while `o_valid & ~i_ready`, `o_data` is stable. Upstream can still push until all `STAGES` stages are valid. Then `o_ready = 0`.
- Full pipeline with `i_ready = 1`: `o_ready = 1` in the same cycle, giving simultaneous push and pop. `o_count` is unchanged.
- `i_flush` and `i_rst` take effect at the next rising edge. Outputs change only after that edge, except `o_ready`, which drops combinationally with `i_flush`.
- Reset asserted mid-stream: all held beats are lost after the edge. No partial state remains.

## Test plan
- Reset: assert `i_rst` 2 cycles with `RST_VALUE=32'hDEAD_BEEF` and `i_valid=1` -> `o_valid=0`, `o_data=32'hDEADBEEF`, `o_count=0` after the edge, and no beat accepted.
- Latency/throughput (STAGES=3): push 0x1..0x8 back-to-back with `i_ready=1` -> 0x1 appears at output 3 cycles after its push, then one value per cycle in order, `o_count` steady at 3.
- Backpressure fill: STAGES=3, `i_ready=0`, push 0xA,0xB,0xC,0xD -> 0xA..0xC accepted, `o_ready=0` on 0xD, `o_count=3`, `o_data=0xA` stable. Then `i_ready=1` -> 0xA,0xB,0xC,0xD delivered in order.
- Bubble collapse: STAGES=4, push 0x1, idle 2 cycles, push 0x2, with `i_ready=0` throughout -> both beats pack into stages 3 and 2, `o_count=2`. On release they are delivered on consecutive cycles.
- Flush: fill with 3 beats, pulse `i_flush` with `i_valid=1`, data 0x55 -> `o_ready=0` that cycle, next cycle `o_valid=0`, `o_count=0`, and 0x55 is never delivered.
- Reset over flush plus full push/pop: with the pipeline full, `i_ready=1` and `i_valid=1`, check that `o_count` is unchanged. Then assert `i_rst` and `i_flush` together -> reset values, with `o_data=RST_VALUE`.
